data_sync_tx: RTL and testbench

Source-domain sender for the `data_sync` CDC stage. It accepts words from a valid/ready producer and holds each word stable on `dout` while running a four-phase request/acknowledge handshake. `dready_o` drives the destination `dready_i`, and the destination `dready_o` returns as `ack_i`. `data_sync_tx` sits directly upstream of `data_sync` and is the only agent allowed to change `data_sync.din`.

---
 rtl/data_sync_pkg.sv | 26 ++
 rtl/sync_bit.sv | 33 +++
 rtl/data_sync_tx.sv | 178 +++++++++++++++++
 tb/tb_data_sync_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_sync_pkg
//  Purpose  : Shared definitions for the data_sync CDC stage and its
//             source-side sender data_sync_tx. It holds the default
//             synchronizer depth and word width, plus the sender FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package data_sync_pkg;

    // Default synchronizer depth, shared by both sides of the crossing
    localparam int c_ds_stages = 2;

    // Default data word width
    localparam int c_ds_dwidth = 8;

    // Sender handshake states; the 2-bit encoding is kept stable for legacy users
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } ds_tx_state_t;

endpackage : data_sync_pkg
`default_nettype wire

// File: rtl/sync_bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sync_bit
//  Purpose  : STAGES-deep single-bit synchronizer with asynchronous
//             active-low reset. The chain resets to 0. Every flop carries
//             ASYNC_REG so that placement keeps the stages together.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the metastability chain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/data_sync_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : data_sync_tx
//  Purpose  : Source-domain sender for the data_sync CDC stage. It accepts
//             words from a valid/ready producer, holds each word on dout and
//             runs a four-phase dready_o/ack_i handshake. ack_i is
//             synchronized locally, and the FSM reacts only to the
//             synchronized copy.
//  Options  : DATA_SYNC_TX_SKID_EN - adds a one-entry pending register, so
//             one word can be accepted while a handshake is in flight. That
//             word is launched straight from ACK_LOW without visiting IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module data_sync_tx
    import data_sync_pkg::*;
#(
    parameter int STAGES = c_ds_stages,
    parameter int DWIDTH = c_ds_dwidth
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ack_i,
    output logic [DWIDTH-1:0] dout,
    output logic              dready_o,
    output logic              busy
);

    localparam logic [1:0] c_st_idle    = IDLE;
    localparam logic [1:0] c_st_req     = REQ;
    localparam logic [1:0] c_st_ack_low = ACK_LOW;

    logic [1:0]        r_state;
    logic [DWIDTH-1:0] r_dout;
    logic              r_dready;

    logic              w_ack_s;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_ack_low_exit;

    // Bring the destination acknowledge into the clk domain
    sync_bit #(
        .STAGES (STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (ack_i),
        .q    (w_ack_s)
    );

    assign w_accept       = in_valid && w_in_ready;
    assign w_ack_low_exit = (r_state == c_st_ack_low) && !w_ack_s;

`ifdef DATA_SYNC_TX_SKID_EN

    logic              r_pend_valid;
    logic [DWIDTH-1:0] r_pend_data;
    logic              w_to_pend;

    // In IDLE the slot is always empty, so only a stale acknowledge stalls
    // the producer. In the busy states, readiness follows slot occupancy.
    assign w_in_ready = (r_state == c_st_idle) ? !w_ack_s : !r_pend_valid;

    // A word accepted while a handshake is still running parks in the slot.
    // On the ACK_LOW exit edge it is launched directly instead.
    assign w_to_pend = w_accept &&
                       ((r_state == c_st_req) ||
                        ((r_state == c_st_ack_low) && w_ack_s));

    // Pending slot: fill during a handshake, and drain on the ACK_LOW exit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else if (w_ack_low_exit && r_pend_valid) begin
            r_pend_valid <= 1'b0;
        end else if (w_to_pend) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= in_data;
        end
    end

    // Handshake FSM; dout moves only on the edge that raises dready_o
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= c_st_idle;
            r_dout   <= '0;
            r_dready <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_dout   <= in_data;
                        r_dready <= 1'b1;
                        r_state  <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (w_ack_s) begin
                        r_dready <= 1'b0;
                        r_state  <= c_st_ack_low;
                    end
                end
                c_st_ack_low: begin
                    if (!w_ack_s) begin
                        if (r_pend_valid) begin
                            r_dout   <= r_pend_data;
                            r_dready <= 1'b1;
                            r_state  <= c_st_req;
                        end else if (w_accept) begin
                            r_dout   <= in_data;
                            r_dready <= 1'b1;
                            r_state  <= c_st_req;
                        end else begin
                            r_state  <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_dready <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

`else

    // Words are taken only in IDLE, and only once any stale acknowledge has cleared
    assign w_in_ready = (r_state == c_st_idle) && !w_ack_s;

    // Handshake FSM; dout moves only on the edge that raises dready_o
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= c_st_idle;
            r_dout   <= '0;
            r_dready <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_dout   <= in_data;
                        r_dready <= 1'b1;
                        r_state  <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (w_ack_s) begin
                        r_dready <= 1'b0;
                        r_state  <= c_st_ack_low;
                    end
                end
                c_st_ack_low: begin
                    if (w_ack_low_exit) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_dready <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

`endif

    assign in_ready = w_in_ready;
    assign dout     = r_dout;
    assign dready_o = r_dready;
    assign busy     = (r_state != c_st_idle);

endmodule : data_sync_tx
`default_nettype wire

// File: tb/tb_data_sync_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_data_sync_tx
//  Purpose  : Self-checking bench for data_sync_tx. It runs a directed vector
//             table, multi-cycle corner sequences and a random stream against
//             a destination model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_sync_tx;

`ifdef DATA_SYNC_TX_SKID_EN
    localparam bit c_skid = 1'b1;
`else
    localparam bit c_skid = 1'b0;
`endif
    localparam int c_nwords = 1000;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       ack_i    = 1'b0;
    logic       in_ready;
    logic [7:0] dout;
    logic       dready_o;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    data_sync_tx #(
        .STAGES (2),
        .DWIDTH (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ack_i    (ack_i),
        .dout     (dout),
        .dready_o (dready_o),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       a;
        logic [7:0] e_dout;
        logic       e_rdy;
        logic       e_busy;
        logic       e_irdy;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {21'd0, dout, dready_o, busy, in_ready};
    endfunction

    function automatic void add(input logic [7:0] d, input logic v, input logic a,
                                input logic [7:0] ed, input logic er, input logic eb,
                                input logic ei);
        vec_t x;
        x.d = d; x.v = v; x.a = a;
        x.e_dout = ed; x.e_rdy = er; x.e_busy = eb; x.e_irdy = ei;
        tbl.push_back(x);
    endfunction

    task automatic do_ack(input string name);
        @(negedge clk) ack_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk({name, "_drop"}, 32'(dready_o), 32'd0);
        @(negedge clk) ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Destination-side stability watch: a held request never sees dout move
    logic [7:0] prev_dout = 8'h00;
    logic       prev_dr   = 1'b0;
    always @(negedge clk) begin
        if (rstn && prev_dr && dready_o) chk("dout_stable", 32'(dout), 32'(prev_dout));
        prev_dout = dout;
        prev_dr   = dready_o && rstn;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #2 rstn = 1'b0;
        #1 chk("reset_state", outs(), {21'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- vector table ----------------
        //    data  v  a   dout  rdy busy irdy
        add(8'h3C,1,0, 8'h3C,1,1,c_skid);
        add(8'h00,0,0, 8'h3C,1,1,c_skid);
        add(8'h00,0,1, 8'h3C,1,1,c_skid);
        add(8'h00,0,1, 8'h3C,1,1,c_skid);
        add(8'h00,0,1, 8'h3C,0,1,c_skid);   // third edge after ack rise
        add(8'h00,0,0, 8'h3C,0,1,c_skid);
        add(8'h00,0,0, 8'h3C,0,1,c_skid);
        add(8'h00,0,0, 8'h3C,0,0,1'b1);     // third edge after ack fall
        add(8'h00,0,1, 8'h3C,0,0,1'b1);
        add(8'h00,0,1, 8'h3C,0,0,1'b0);     // stale ack reaches ack_s
        add(8'h77,1,1, 8'h3C,0,0,1'b0);
        add(8'h77,1,0, 8'h3C,0,0,1'b0);
        add(8'h77,1,0, 8'h3C,0,0,1'b1);
        add(8'h77,1,0, 8'h77,1,1,c_skid);
        add(8'h00,0,1, 8'h77,1,1,c_skid);
        add(8'h00,0,1, 8'h77,1,1,c_skid);
        add(8'h00,0,1, 8'h77,0,1,c_skid);
        add(8'h00,0,0, 8'h77,0,1,c_skid);
        add(8'h00,0,0, 8'h77,0,1,c_skid);
        add(8'h00,0,0, 8'h77,0,0,1'b1);
        add(8'hFF,1,0, 8'hFF,1,1,c_skid);
        add(8'h00,0,1, 8'hFF,1,1,c_skid);
        add(8'h00,0,1, 8'hFF,1,1,c_skid);
        add(8'h00,0,1, 8'hFF,0,1,c_skid);
        add(8'h00,0,0, 8'hFF,0,1,c_skid);
        add(8'h00,0,0, 8'hFF,0,1,c_skid);
        add(8'h00,0,0, 8'hFF,0,0,1'b1);
        foreach (tbl[i]) begin
            @(negedge clk);
            in_data  = tbl[i].d;
            in_valid = tbl[i].v;
            ack_i    = tbl[i].a;
            @(posedge clk);
            #1 chk($sformatf("tbl[%0d]", i), outs(),
                   {21'd0, tbl[i].e_dout, tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_irdy});
        end
        @(negedge clk) in_valid = 1'b0;

        // ---------------- asynchronous reset mid-REQ ----------------
        @(negedge clk) begin in_data = 8'hA5; in_valid = 1'b1; end
        @(posedge clk);
        #1 chk("rst_pre_dout", 32'(dout), 32'h0000_00A5);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1 chk("rst_async", outs(), {21'd0, 8'h00, 1'b0, 1'b0, 1'b1});
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- back-to-back ----------------
        in_data = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        #1 chk("b2b_first", {24'd0, dout}, {24'd0, 8'h01});
`ifdef DATA_SYNC_TX_SKID_EN
        @(negedge clk) in_data = 8'h02;
        chk("b2b_skid_open", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_slot_full", 32'(in_ready), 32'd0);
        chk("b2b_hold", 32'(dout), 32'h01);
        @(negedge clk) ack_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("b2b_ack_drop", {23'd0, dout, dready_o}, {23'd0, 8'h01, 1'b0});
        @(negedge clk) ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("b2b_exit_cycle", {23'd0, dout, dready_o, in_ready},
               {23'd0, 8'h01, 1'b0, 1'b0});
        @(posedge clk);
        #1 chk("b2b_rerise", outs(), {21'd0, 8'h02, 1'b1, 1'b1, 1'b1});
        do_ack("b2b_second");
`else
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_data = 8'h02;
            ack_i   = (k < 3);
            chk($sformatf("b2b_wait[%0d]", k), 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 chk("b2b_idle", outs(), {21'd0, 8'h01, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_second_launch", {23'd0, dout, dready_o}, {23'd0, 8'h02, 1'b1});
        do_ack("b2b_second");
`endif

        // ---------------- stale ack through reset ----------------
        @(negedge clk) begin rstn = 1'b0; ack_i = 1'b1; in_valid = 1'b0; end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("stale_irdy", 32'(in_ready), 32'd0);
        @(negedge clk) begin in_data = 8'h5A; in_valid = 1'b1; end
        repeat (3) @(posedge clk);
        #1 chk("stale_noreq", {29'd0, dready_o, busy, in_ready}, 32'd0);
        @(negedge clk) ack_i = 1'b0;
        @(posedge clk);
        #1 chk("stale_edge1", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("stale_edge2", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("stale_accept", {23'd0, dout, dready_o}, {23'd0, 8'h5A, 1'b1});
        do_ack("stale_word");

        // ---------------- ack glitch between edges ----------------
        @(negedge clk) begin in_data = 8'hC3; in_valid = 1'b1; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 ack_i = 1'b1;
        #2 ack_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 chk($sformatf("glitch_hold[%0d]", k), {22'd0, dout, dready_o, busy},
                   {22'd0, 8'hC3, 1'b1, 1'b1});
        end
        do_ack("glitch_word");

        // ---------------- random stream ----------------
        @(negedge clk);
        fork
            begin : drv
                for (int w = 0; w < c_nwords; w++) begin
                    logic [7:0] word;
                    bit         got;
                    word = 8'($urandom);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    in_data  = word;
                    in_valid = 1'b1;
                    got      = 1'b0;
                    for (int t = 0; t < 1000 && !got; t++) begin
                        if (in_ready) begin
                            exp_q.push_back(word);
                            got = 1'b1;
                        end
                        @(negedge clk);
                    end
                    in_valid = 1'b0;
                    if (!got) begin
                        chk("stream_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                end
            end
            begin : dst
                for (int n = 0; n < c_nwords; n++) begin
                    int t;
                    t = 0;
                    while (!dready_o && t < 2000) begin @(negedge clk); t++; end
                    if (!dready_o) begin
                        chk("stream_req_timeout", 32'd0, 32'd1);
                        break;
                    end
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    if (exp_q.size() == 0) begin
                        chk("stream_extra_word", 32'(dout), 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("stream_word[%0d]", n), 32'(dout), 32'(exp_q.pop_front()));
                    end
                    ack_i = 1'b1;
                    t = 0;
                    while (dready_o && t < 2000) begin @(negedge clk); t++; end
                    if (dready_o) begin
                        chk("stream_ack_timeout", 32'd0, 32'd1);
                        break;
                    end
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    ack_i = 1'b0;
                    @(negedge clk);
                end
            end
        join
        chk("stream_drain", 32'(exp_q.size()), 32'd0);
        repeat (6) @(negedge clk);
        chk("stream_end_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_data_sync_tx
`default_nettype wire
